// File: rtl/sram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sram_ctrl_pkg
//   Shared definitions for the asynchronous-SRAM controller:
//     state_t      - controller FSM states
//     WAIT_MAX     - largest legal wait-state setting
//     WCNT_W       - width of the wait-state down-counter
// ----------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int WAIT_MAX = 15;
    localparam int WCNT_W   = 4;   // holds 0..WAIT_MAX

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ACC   = 3'd1,
        TURN     = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5
    } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// ----------------------------------------------------------------------------
// sram_wait_counter
//   Loadable wait-state down-counter. A phase that must last N+1 cycles loads
//   N on the edge that enters it, then decrements once per cycle until done.
//   Ports:
//     clk1   - clock
//     reset  - synchronous active-high reset, clears the count
//     load   - load 'value' on this edge (takes priority over en)
//     value  - count to load
//     en     - decrement on this edge (saturates at zero)
//     done   - count is zero: the current cycle is the last of the phase
// ----------------------------------------------------------------------------
module sram_wait_counter
    import sram_ctrl_pkg::*;
(
    input  logic              clk1,
    input  logic              reset,
    input  logic              load,
    input  logic [WCNT_W-1:0] value,
    input  logic              en,
    output logic              done
);

    logic [WCNT_W-1:0] cnt;

    always_ff @(posedge clk1) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// ----------------------------------------------------------------------------
// sram_ctrl
//   Single-port controller for an asynchronous SRAM with a bidirectional data
//   bus. One access is in flight at a time; requests use a valid/ready
//   handshake and complete with a one-cycle rsp_valid pulse.
//
//   Read : IDLE -> RD_ACC (WAIT+1) -> TURN -> IDLE      latency WAIT+2
//   Write: IDLE -> WR_SETUP -> WR_PULSE (WAIT+1) -> WR_HOLD -> IDLE
//                                                        latency WAIT+3
//
//   Parameters:
//     AW   - word address width
//     DW   - data width (multiple of 8)
//     WAIT - access wait states, 0..WAIT_MAX
//
//   Ports:
//     clk1, reset            - clock, synchronous active-high reset
//     req_valid/req_ready    - request handshake
//     req_write              - 1 = write, 0 = read
//     req_addr, req_wdata    - request address / write data
//     rsp_valid              - completion pulse (reads and writes)
//     rsp_rdata              - read data, meaningful while rsp_valid after a read
//     sram_addr, sram_dout   - SRAM address / write data
//     sram_drive             - output enable for the board-level data tristate
//     sram_din               - SRAM read data
//     sram_ce_n/oe_n/we_n    - active-low SRAM strobes
// ----------------------------------------------------------------------------
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int WAIT = 1
) (
    input  logic          clk1,
    input  logic          reset,

    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,

    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,

    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dout,
    output logic          sram_drive,
    input  logic [DW-1:0] sram_din,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
);

    // WAIT outside 0..WAIT_MAX does not fit the counter; it is truncated here.
    localparam logic [WCNT_W-1:0] WAIT_CNT = WCNT_W'(WAIT);

    state_t state, state_n;

    logic accept;
    logic cnt_load;
    logic cnt_en;
    logic cnt_done;

    // ------------------------------------------------------------------
    // Wait-state counter: loaded with WAIT on entry to RD_ACC (at accept)
    // and on entry to WR_PULSE (from WR_SETUP); done marks the last cycle.
    // ------------------------------------------------------------------
    sram_wait_counter u_wait (
        .clk1  (clk1),
        .reset (reset),
        .load  (cnt_load),
        .value (WAIT_CNT),
        .en    (cnt_en),
        .done  (cnt_done)
    );

    // ready is masked by reset so nothing is accepted on a reset edge
    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk1) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and counter control
    // ------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_write) begin
                        state_n = WR_SETUP;
                    end else begin
                        state_n  = RD_ACC;
                        cnt_load = 1'b1;
                    end
                end
            end
            RD_ACC: begin
                if (cnt_done) state_n = TURN;
                else          cnt_en  = 1'b1;
            end
            TURN: begin
                state_n = IDLE;
            end
            WR_SETUP: begin
                state_n  = WR_PULSE;
                cnt_load = 1'b1;
            end
            WR_PULSE: begin
                if (cnt_done) state_n = WR_HOLD;
                else          cnt_en  = 1'b1;
            end
            WR_HOLD: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Strobes are pure decodes of the registered state, so they change
    // only at clock edges. oe_n is low only in RD_ACC and we_n only in
    // WR_PULSE, while drive spans the whole write; the two bus directions
    // can therefore never overlap and TURN separates a read from the next
    // write.
    // ------------------------------------------------------------------
    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_drive = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            RD_ACC: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
            end
            TURN: begin
                rsp_valid = 1'b1;
            end
            WR_SETUP: begin
                sram_ce_n  = 1'b0;
                sram_drive = 1'b1;
            end
            WR_PULSE: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_drive = 1'b1;
            end
            WR_HOLD: begin
                sram_ce_n  = 1'b0;
                sram_drive = 1'b1;
                rsp_valid  = 1'b1;
            end
            default: begin
                sram_ce_n = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. Address/data are captured only at acceptance,
    // so they stay stable for the whole access and hold in IDLE. Read data
    // is sampled on the edge that ends the final RD_ACC cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk1) begin
        if (reset) begin
            sram_addr <= '0;
            sram_dout <= '0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                sram_addr <= req_addr;
                if (req_write) sram_dout <= req_wdata;
            end
            if ((state == RD_ACC) && cnt_done) begin
                rsp_rdata <= sram_din;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram_ctrl
//   Two controllers (WAIT=1 and WAIT=0) share one behavioural SRAM and one
//   request bus; 'sel' routes req_valid to one of them and selects which
//   outputs are observed. Expected responses are queued at acceptance and
//   compared when rsp_valid appears.
// ----------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk1 = 1'b0;
    logic          reset;
    logic          preload;
    logic          sel;          // 0: WAIT=1 instance, 1: WAIT=0 instance
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          rdy1, rv1, drv1, ce1, oe1, we1;
    logic [DW-1:0] rd1, sd1, din1;
    logic [AW-1:0] sa1;
    logic          rdy0, rv0, drv0, ce0, oe0, we0;
    logic [DW-1:0] rd0, sd0, din0;
    logic [AW-1:0] sa0;

    logic          rdy, rv, drv, ce, oe, we;
    logic [DW-1:0] rd, sd;
    logic [AW-1:0] sa;

    logic [DW-1:0] mem    [0:255];
    logic [DW-1:0] shadow [0:255];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
        int            lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk1 = ~clk1;

    sram_ctrl #(.AW(AW), .DW(DW), .WAIT(1)) dut1 (
        .clk1(clk1), .reset(reset),
        .req_valid(req_valid && !sel), .req_ready(rdy1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1),
        .sram_addr(sa1), .sram_dout(sd1), .sram_drive(drv1), .sram_din(din1),
        .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1)
    );

    sram_ctrl #(.AW(AW), .DW(DW), .WAIT(0)) dut0 (
        .clk1(clk1), .reset(reset),
        .req_valid(req_valid && sel), .req_ready(rdy0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0),
        .sram_addr(sa0), .sram_dout(sd0), .sram_drive(drv0), .sram_din(din0),
        .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0)
    );

    assign rdy = sel ? rdy0 : rdy1;
    assign rv  = sel ? rv0  : rv1;
    assign rd  = sel ? rd0  : rd1;
    assign sd  = sel ? sd0  : sd1;
    assign sa  = sel ? sa0  : sa1;
    assign drv = sel ? drv0 : drv1;
    assign ce  = sel ? ce0  : ce1;
    assign oe  = sel ? oe0  : oe1;
    assign we  = sel ? we0  : we1;

    function automatic logic [DW-1:0] pat(int i);
        return DW'(i * 257) ^ 16'h3C3C;
    endfunction

    // Behavioural SRAM: asynchronous read, write on edges while we_n is low
    assign din1 = mem[sa1];
    assign din0 = mem[sa0];

    always @(posedge clk1) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
            mem[8'h12] <= 16'hBEEF;
        end else begin
            if (!ce1 && !we1 && drv1) mem[sa1] <= sd1;
            if (!ce0 && !we0 && drv0) mem[sa0] <= sd0;
        end
    end

    // Bus-direction safety monitor on both instances
    always @(negedge clk1) begin
        if (!reset) begin
            checks += 4;
            assert (!(!oe1 && drv1)) else begin errors++; $error("FAIL mon_oe_drive1: observed oe_n=%0b drive=%0b required no overlap", oe1, drv1); end
            assert (!(!we1 && !drv1)) else begin errors++; $error("FAIL mon_we_drive1: observed we_n=%0b drive=%0b required drive with we", we1, drv1); end
            assert (!(!oe0 && drv0)) else begin errors++; $error("FAIL mon_oe_drive0: observed oe_n=%0b drive=%0b required no overlap", oe0, drv0); end
            assert (!(!we0 && !drv0)) else begin errors++; $error("FAIL mon_we_drive0: observed we_n=%0b drive=%0b required drive with we", we0, drv0); end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the response seen at cycle k
    task automatic take_rsp(input int k, input string tag);
        exp_t e;
        chk({tag, "_outstanding"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 32'(k), 32'(e.lat));
            if (!e.wr) chk({tag, "_rdata"}, 32'(rd), 32'(e.data));
        end
    endtask

    // Called at a negedge with req fields set; returns at the negedge of cycle 1
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int lat, input logic track);
        exp_t e;
        int k;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        for (k = 0; k < 40 && !rdy; k++) @(negedge clk1);
        chk("accept_ready", 32'(rdy), 32'd1);
        @(posedge clk1);
        if (track) begin
            e.wr = wr; e.data = wr ? d : shadow[a]; e.lat = lat;
            sb.push_back(e);
            if (wr) shadow[a] = d;
        end
        @(negedge clk1);
        req_valid = 1'b0;
    endtask

    // Starts at the cycle-1 negedge; tracks strobe activity until rsp_valid
    task automatic wait_rsp(input string tag, output int oe_first, output int oe_cnt,
                            output int we_first, output int we_cnt);
        int   k;
        logic found;
        found = 1'b0; oe_first = 0; oe_cnt = 0; we_first = 0; we_cnt = 0;
        for (k = 1; k <= 40; k++) begin
            if (!oe) begin oe_cnt++; if (oe_first == 0) oe_first = k; end
            if (!we) begin we_cnt++; if (we_first == 0) we_first = k; end
            if (rv) begin found = 1'b1; break; end
            @(negedge clk1);
        end
        chk({tag, "_rsp_seen"}, 32'(found), 32'd1);
        if (found) take_rsp(k, tag);
    endtask

    task automatic access(input string tag, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int lat);
        int of, oc, wf, wc;
        issue(wr, a, d, lat, 1'b1);
        wait_rsp(tag, of, oc, wf, wc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int of, oc, wf, wc, acc, k;

        reset = 1'b1; preload = 1'b1; sel = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) shadow[i] = pat(i);
        shadow[8'h12] = 16'hBEEF;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk1);
        chk("rst_ready1", 32'(rdy1), 32'd0);
        chk("rst_ready0", 32'(rdy0), 32'd0);
        chk("rst_strobes", 32'({ce1, oe1, we1, drv1, rv1}), 32'b11100);
        chk("rst_rdata", 32'(rd1), 32'd0);
        chk("rst_addr", 32'(sa1), 32'd0);
        chk("rst_dout", 32'(sd1), 32'd0);
        reset = 1'b0; preload = 1'b0;
        @(negedge clk1);
        chk("idle_ready", 32'(rdy), 32'd1);

        // ---------------- WAIT=1 read of preloaded word ----------------
        issue(1'b0, 8'h12, '0, 3, 1'b1);
        wait_rsp("rd12", of, oc, wf, wc);
        chk("rd12_oe_first", 32'(of), 32'd1);
        chk("rd12_oe_cycles", 32'(oc), 32'd2);
        @(negedge clk1);
        chk("rd12_ready_after", 32'(rdy), 32'd1);

        // ---------------- WAIT=1 write then read-back ----------------
        issue(1'b1, 8'h34, 16'h5A5A, 4, 1'b1);
        wait_rsp("wr34", of, oc, wf, wc);
        chk("wr34_we_first", 32'(wf), 32'd2);
        chk("wr34_we_cycles", 32'(wc), 32'd2);
        chk("wr34_no_oe", 32'(oc), 32'd0);
        chk("wr34_addr_hold", 32'(sa), 32'h34);
        chk("wr34_dout_hold", 32'(sd), 32'h5A5A);
        @(negedge clk1);
        access("rd34", 1'b0, 8'h34, '0, 3);

        // ---------------- back-to-back: read then held write ----------------
        @(negedge clk1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h01; req_wdata = '0;
        for (k = 0; k < 40 && !rdy; k++) @(negedge clk1);
        @(posedge clk1);
        sb.push_back('{1'b0, shadow[8'h01], 3});
        @(negedge clk1);
        req_write = 1'b1; req_addr = 8'h02; req_wdata = 16'h1234;
        acc = 0;
        for (k = 1; k <= 40; k++) begin
            if (rv) take_rsp(k, "b2b_rd");
            if (rdy) begin acc = k; break; end
            @(negedge clk1);
        end
        chk("b2b_wr_accept_cycle", 32'(acc), 32'd4);
        @(posedge clk1);
        sb.push_back('{1'b1, 16'h1234, 4});
        shadow[8'h02] = 16'h1234;
        @(negedge clk1);
        req_valid = 1'b0;
        wait_rsp("b2b_wr", of, oc, wf, wc);
        @(negedge clk1);
        access("b2b_rd2", 1'b0, 8'h02, '0, 3);

        // ---------------- WAIT=0 instance ----------------
        @(negedge clk1);
        sel = 1'b1;
        @(negedge clk1);
        issue(1'b0, 8'h12, '0, 2, 1'b1);
        wait_rsp("w0_rd", of, oc, wf, wc);
        chk("w0_rd_oe_cycles", 32'(oc), 32'd1);
        @(negedge clk1);
        issue(1'b1, 8'h55, 16'hC0DE, 3, 1'b1);
        wait_rsp("w0_wr", of, oc, wf, wc);
        chk("w0_wr_we_cycles", 32'(wc), 32'd1);
        @(negedge clk1);
        access("w0_rd55", 1'b0, 8'h55, '0, 2);
        @(negedge clk1);
        access("w0_rdff", 1'b0, 8'hFF, '0, 2);
        @(negedge clk1);
        sel = 1'b0;

        // ---------------- reset in second WR_PULSE cycle ----------------
        @(negedge clk1);
        issue(1'b1, 8'h40, 16'hAAAA, 4, 1'b0);   // cycle 1 (WR_SETUP)
        @(negedge clk1);                           // cycle 2 (WR_PULSE 1)
        @(negedge clk1);                           // cycle 3 (WR_PULSE 2)
        chk("rstw_in_pulse", 32'(we), 32'd0);
        reset = 1'b1;
        @(negedge clk1);
        chk("rstw_strobes", 32'({ce, oe, we, drv}), 32'b1110);
        chk("rstw_no_rsp", 32'(rv), 32'd0);
        chk("rstw_ready_in_reset", 32'(rdy), 32'd0);
        chk("rstw_addr", 32'(sa), 32'd0);
        chk("rstw_dout", 32'(sd), 32'd0);
        reset = 1'b0;
        @(negedge clk1);
        chk("rstw_ready_after", 32'(rdy), 32'd1);
        chk("rstw_no_rsp_after", 32'(rv), 32'd0);

        // ---------------- boundary addresses ----------------
        @(negedge clk1);
        access("bnd_wr00", 1'b1, 8'h00, 16'h0F0F, 4);
        @(negedge clk1);
        access("bnd_wrff", 1'b1, 8'hFF, 16'hF0F0, 4);
        @(negedge clk1);
        access("bnd_rdff", 1'b0, 8'hFF, '0, 3);
        @(negedge clk1);
        access("bnd_rd00", 1'b0, 8'h00, '0, 3);
        @(negedge clk1);
        access("bnd_rd7f", 1'b0, 8'h7F, '0, 3);
        @(negedge clk1);
        access("bnd_rd80", 1'b0, 8'h80, '0, 3);

        repeat (3) @(negedge clk1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8: address width.
REQ-002 SHALL have parameter DW, default 16: data width, multiple of 8.
REQ-003 SHALL have parameter WAIT, default 1: access wait states, legal range 0..15.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk1 and reset.
REQ-005 SHALL have port clk1, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-008 SHALL have port req_ready, output, 1 bit: the controller accepts a request this cycle.
REQ-009 SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, AW bits: word address.
REQ-011 SHALL have port req_wdata, input, DW bits: write data.
REQ-012 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse for a read or a write.
REQ-013 SHALL have port rsp_rdata, output, DW bits: read data; valid only while rsp_valid=1 after a read.
REQ-014 SHALL have port sram_addr, output, AW bits: SRAM address.
REQ-015 SHALL have port sram_dout, output, DW bits: SRAM write data.
REQ-016 SHALL have port sram_drive, output, 1 bit: tristate enable for sram_dout on the board.
REQ-017 SHALL have port sram_din, input, DW bits: SRAM read data.
REQ-018 SHALL have ports sram_ce_n, sram_oe_n and sram_we_n, outputs, 1 bit each: active-low strobes.

Function
REQ-019 SHALL accept a request on a rising edge only when req_valid=1 and req_ready=1; req_addr, req_write and req_wdata are registered at acceptance.
REQ-020 SHALL drive req_ready=1 only in IDLE and never while reset=1.
REQ-021 SHALL implement these states:
- IDLE, RD_ACC, TURN, WR_SETUP, WR_PULSE, WR_HOLD.
- Read path: IDLE -> RD_ACC -> TURN -> IDLE.
- Write path: IDLE -> WR_SETUP -> WR_PULSE -> WR_HOLD -> IDLE.
REQ-022 SHALL hold RD_ACC for WAIT+1 cycles with ce_n=0, oe_n=0, we_n=1, drive=0.
REQ-023 SHALL register sram_din into rsp_rdata at the end of the last RD_ACC cycle.
REQ-024 SHALL pulse rsp_valid in TURN for reads; read latency is WAIT+2 cycles from the acceptance edge to rsp_valid.
REQ-025 SHALL use TURN for bus turnaround: all strobes inactive and drive=0, so no request is accepted in the cycle after read data returns.
REQ-026 SHALL drive the write strobes as follows:
- WR_SETUP, 1 cycle: ce_n=0, we_n=1, drive=1.
- WR_PULSE, WAIT+1 cycles: ce_n=0, we_n=0, drive=1.
- WR_HOLD, 1 cycle: ce_n=0, we_n=1, drive=1, with rsp_valid=1.
REQ-027 SHALL hold sram_addr and sram_dout stable from WR_SETUP through WR_HOLD inclusive.
REQ-028 SHALL make a write complete WAIT+3 cycles after acceptance, with rsp_valid in WR_HOLD.
REQ-029 SHALL keep ce_n=1, oe_n=1, we_n=1 and drive=0 in IDLE; sram_addr holds its last value.
REQ-030 SHALL never assert oe_n=0 while drive=1, and never assert we_n=0 while drive=0.
REQ-031 SHALL ignore req_* inputs while req_ready=0; a held req_valid is accepted on the first IDLE edge.
REQ-032 SHALL, with WAIT=0, give RD_ACC and WR_PULSE exactly one cycle each.

Reset
REQ-033 SHALL, on any rising edge with reset=1, enter IDLE from any state, including mid-access, and apply these values:
- ce_n=1, oe_n=1, we_n=1, drive=0.
- rsp_valid=0, rsp_rdata=0, sram_addr=0, sram_dout=0.
- Wait counter = 0.
REQ-034 SHALL discard an access interrupted by reset and produce no rsp_valid for it.

Structure
REQ-035 SHALL place the state enum type and the WAIT range limit constant in package sram_ctrl_pkg.
REQ-036 SHALL implement the loadable wait-state down-counter as sub-module sram_wait_counter, with inputs load, value, en and output done.

Verification
REQ-037 SHALL cover read: WAIT=1, SRAM[0x12]=0xBEEF, read 0x12 accepted at cycle 0 -> oe_n=0 in cycles 1-2, rsp_valid=1 with rsp_rdata=0xBEEF at cycle 3, req_ready=1 at cycle 4.
REQ-038 SHALL cover write: WAIT=1, write 0x5A5A to 0x34 at cycle 0 -> we_n=0 in cycles 2-3, rsp_valid at cycle 4, then a read of 0x34 returns 0x5A5A.
REQ-039 SHALL cover back-to-back traffic: read 0x01 then a held write request -> the write is not accepted before the TURN cycle ends, and drive=1 never overlaps oe_n=0.
REQ-040 SHALL cover WAIT=0: a read returns at cycle 2 and a write acknowledges at cycle 3.
REQ-041 SHALL cover reset mid-write: reset=1 in the second WR_PULSE cycle -> next edge gives all strobes high, drive=0, no rsp_valid, and IDLE with req_ready=1 after reset falls.
REQ-042 SHALL cover boundary addresses: AW=8, accesses to 0x00 and 0xFF -> correct data with no wrap or aliasing.
